out_wcombiner: RTL and testbench

//  Output write-combining stage directly downstream of u8mac; upstream of the AXI write master.

---
 rtl/out_wcombiner_if.sv | 12 +
 rtl/out_wcombiner.sv | 220 ++++++++++++++++++++++
 tb/tb_out_wcombiner.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/out_wcombiner_if.sv
// Burst write bus between the output write-combining stage (master) and the AXI write master (slave).
interface out_wcombiner_if;
  logic        wreq;
  logic        wack;
  logic [31:0] wadr;
  logic [63:0] wdata;
  logic [7:0]  wstb;
  logic [7:0]  wlen;

  modport master (output wreq, wadr, wdata, wstb, wlen, input wack);
  modport slave  (input wreq, wadr, wdata, wstb, wlen, output wack);
endinterface

// File: rtl/out_wcombiner.sv
// Output write-combining stage: packs result bytes into two ping-pong line buffers and drains them
// as 64-bit strobed bursts. Define OWC_TRIM_BURST_EN to trim each burst to its dirty word span.
module out_wcombiner #(
  parameter int LINE_WORDS = 32
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            civ_i,
  input  logic            flreq_i,
  output logic            flbsy_o,
  input  logic [23:0]     adr_i,
  input  logic            we_i,
  input  logic [7:0]      dw_i,
  output logic            rdy_o,
  output logic            cmpl_o,
  out_wcombiner_if.master wr
);
  localparam int LINE_BYTES = 8 * LINE_WORDS;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int WRD_W      = $clog2(LINE_WORDS);
  localparam int TAG_W      = 24 - OFF_W;

  typedef enum logic [1:0] {L_EMPTY, L_ACTIVE, L_PENDING, L_DRAIN} line_st_e;
  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_BURST} drn_st_e;

  line_st_e                   st_q   [2];
  line_st_e                   st_d   [2];
  logic [TAG_W-1:0]           tag_q  [2];
  logic [TAG_W-1:0]           tag_d  [2];
  logic [LINE_BYTES-1:0]      mask_q [2];
  logic [LINE_BYTES-1:0]      mask_d [2];
  logic [LINE_BYTES-1:0][7:0] data_q [2];
  logic                       older_q, older_d;
  logic                       flbsy_q, cmpl_q;

  drn_st_e          d_st_q;
  logic             drn_idx_q;
  logic [WRD_W-1:0] beat_q, last_q, beat_nx, first_w, last_w;
  logic             wreq_q;
  logic [31:0]      wadr_q;
  logic [63:0]      wdata_q;
  logic [7:0]       wstb_q, wlen_q;

  logic [TAG_W-1:0] in_tag;
  logic [OFF_W-1:0] in_off;
  logic has_act, act_idx, any_emp, emp_idx, hit, wr_en, wr_idx;
  logic drn_sel, drn_start, drn_done, all_emp;

  assign in_tag  = adr_i[23:OFF_W];
  assign in_off  = adr_i[OFF_W-1:0];
  assign all_emp = (st_q[0] == L_EMPTY) && (st_q[1] == L_EMPTY);

  // Descending scan so line 0 wins when both lines qualify.
  always_comb begin
    has_act = 1'b0;
    act_idx = 1'b0;
    any_emp = 1'b0;
    emp_idx = 1'b0;
    for (int i = 1; i >= 0; i--) begin
      if (st_q[i] == L_ACTIVE) begin has_act = 1'b1; act_idx = 1'(i); end
      if (st_q[i] == L_EMPTY)  begin any_emp = 1'b1; emp_idx = 1'(i); end
    end
  end

  assign hit   = has_act && (tag_q[act_idx] == in_tag);
  assign rdy_o = hit | any_emp;
  assign wr_en = we_i & rdy_o;

  always_comb begin
    drn_sel = older_q;
    if (st_q[0] == L_PENDING && st_q[1] != L_PENDING)      drn_sel = 1'b0;
    else if (st_q[1] == L_PENDING && st_q[0] != L_PENDING) drn_sel = 1'b1;
  end

  assign drn_start = (d_st_q == D_IDLE) && !civ_i &&
                     ((st_q[0] == L_PENDING) || (st_q[1] == L_PENDING));
  assign drn_done  = (d_st_q == D_BURST) && wr.wack && (beat_q == last_q);

  // Line bookkeeping: byte write first, then flush, then drain events, then invalidate.
  always_comb begin
    // NOTE: every target is defaulted before any conditional update so no latch is inferred.
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      tag_d[i]  = tag_q[i];
      mask_d[i] = mask_q[i];
    end
    older_d = older_q;
    wr_idx  = hit ? act_idx : emp_idx;
    if (wr_en) begin
      if (!hit) begin
        if (has_act) begin
          st_d[act_idx] = L_PENDING;
          if (st_q[~act_idx] != L_PENDING) older_d = act_idx;
        end
        st_d[emp_idx]  = L_ACTIVE;
        tag_d[emp_idx] = in_tag;
      end
      mask_d[wr_idx][in_off] = 1'b1;
    end
    if (flreq_i && !flbsy_q) begin
      for (int i = 0; i < 2; i++) begin
        if (st_d[i] == L_ACTIVE) begin
          if (|mask_d[i]) begin
            st_d[i] = L_PENDING;
            if (st_d[1-i] != L_PENDING) older_d = 1'(i);
          end else begin
            st_d[i] = L_EMPTY;
          end
        end
      end
    end
    if (drn_start) st_d[drn_sel] = L_DRAIN;
    if (drn_done) begin
      st_d[drn_idx_q]   = L_EMPTY;
      mask_d[drn_idx_q] = '0;
    end
    if (civ_i) begin
      for (int i = 0; i < 2; i++) begin
        if (st_d[i] != L_DRAIN) begin
          st_d[i]   = L_EMPTY;
          mask_d[i] = '0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= L_EMPTY;
        tag_q[i]  <= '0;
        mask_q[i] <= '0;
      end
      older_q <= 1'b0;
      flbsy_q <= 1'b0;
      cmpl_q  <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        tag_q[i]  <= tag_d[i];
        mask_q[i] <= mask_d[i];
      end
      older_q <= older_d;
      flbsy_q <= flbsy_q ? !(all_emp && !wreq_q) : flreq_i;
      cmpl_q  <= all_emp && !wreq_q;
    end
  end

  // NOTE: line data is a plain storage array with no reset; the dirty masks alone say what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][in_off] <= dw_i;
  end

`ifdef OWC_TRIM_BURST_EN
  logic [LINE_WORDS-1:0] wdirty;
  always_comb begin
    first_w = '0;
    last_w  = '0;
    for (int w = 0; w < LINE_WORDS; w++) wdirty[w] = |mask_q[drn_idx_q][8*w +: 8];
    for (int w = LINE_WORDS - 1; w >= 0; w--) if (wdirty[w]) first_w = WRD_W'(w);
    for (int w = 0; w < LINE_WORDS; w++)      if (wdirty[w]) last_w  = WRD_W'(w);
  end
`else
  assign first_w = '0;
  assign last_w  = '1;
`endif

  assign beat_nx = beat_q + WRD_W'(1);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      d_st_q    <= D_IDLE;
      drn_idx_q <= 1'b0;
      beat_q    <= '0;
      last_q    <= '0;
      wreq_q    <= 1'b0;
      wadr_q    <= '0;
      wdata_q   <= '0;
      wstb_q    <= '0;
      wlen_q    <= '0;
    end else begin
      case (d_st_q)
        D_IDLE: if (drn_start) begin
          drn_idx_q <= drn_sel;
          d_st_q    <= D_LOAD;
        end
        D_LOAD: begin
          beat_q  <= first_w;
          last_q  <= last_w;
          wadr_q  <= {8'h00, tag_q[drn_idx_q], first_w, 3'b000};
          wlen_q  <= 8'(last_w - first_w);
          wdata_q <= data_q[drn_idx_q][{first_w, 3'b000} +: 8];
          wstb_q  <= mask_q[drn_idx_q][{first_w, 3'b000} +: 8];
          wreq_q  <= 1'b1;
          d_st_q  <= D_BURST;
        end
        D_BURST: if (wr.wack) begin
          if (beat_q == last_q) begin
            wreq_q <= 1'b0;
            d_st_q <= D_IDLE;
          end else begin
            beat_q  <= beat_nx;
            wdata_q <= data_q[drn_idx_q][{beat_nx, 3'b000} +: 8];
            wstb_q  <= mask_q[drn_idx_q][{beat_nx, 3'b000} +: 8];
          end
        end
        default: d_st_q <= D_IDLE;
      endcase
    end
  end

  assign wr.wreq  = wreq_q;
  assign wr.wadr  = wadr_q;
  assign wr.wdata = wdata_q;
  assign wr.wstb  = wstb_q;
  assign wr.wlen  = wlen_q;
  assign flbsy_o  = flbsy_q;
  assign cmpl_o   = cmpl_q;
endmodule

// File: tb/tb_out_wcombiner.sv
// Directed bench for out_wcombiner: a line model pushes expected beats into a scoreboard that a
// negedge monitor pops as the DUT issues them. Honours OWC_TRIM_BURST_EN for expected headers.
module tb_out_wcombiner;
  localparam int LW    = 32;
  localparam int LB    = 8 * LW;
  localparam int OFF_W = $clog2(LB);
  localparam int TAG_W = 24 - OFF_W;

  typedef struct packed {
    logic [31:0] adr;
    logic [7:0]  len;
    logic [63:0] data;
    logic [7:0]  stb;
  } beat_t;

  logic        clk = 1'b0, xrst = 1'b0, civ = 1'b0, flreq = 1'b0, we = 1'b0;
  logic [23:0] adr = '0;
  logic [7:0]  dw = '0;
  logic        flbsy, rdy, cmpl;
  int          wack_mode = 0;

  out_wcombiner_if wr_if ();

  out_wcombiner #(.LINE_WORDS(LW)) dut (
    .clk(clk), .xrst(xrst), .civ_i(civ), .flreq_i(flreq), .flbsy_o(flbsy),
    .adr_i(adr), .we_i(we), .dw_i(dw), .rdy_o(rdy), .cmpl_o(cmpl), .wr(wr_if.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] stbmask(input logic [7:0] s);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  // Scoreboard and reference line model.
  beat_t            sb[$];
  beat_t            mon_e;
  int               mon_beats = 0, wq_cycles = 0;
  logic [31:0]      hdr_adr = '0;
  logic [7:0]       hdr_len = '0;
  logic [7:0]       m_data [LB];
  logic [LB-1:0]    m_mask = '0;
  logic [TAG_W-1:0] m_tag = '0;
  bit               m_valid = 1'b0;

  task automatic push_line();
    int    first, last;
    beat_t b;
    if (m_mask == '0) return;
    first = 0;
    last  = LW - 1;
`ifdef OWC_TRIM_BURST_EN
    first = LW;
    last  = 0;
    for (int w = 0; w < LW; w++)
      if (m_mask[8*w +: 8] != 8'h00) begin
        if (w < first) first = w;
        last = w;
      end
`endif
    for (int w = first; w <= last; w++) begin
      b.adr = (32'(m_tag) << OFF_W) | 32'(8 * first);
      b.len = 8'(last - first);
      for (int k = 0; k < 8; k++) begin
        b.data[8*k +: 8] = m_data[8*w + k];
        b.stb[k]         = m_mask[8*w + k];
      end
      sb.push_back(b);
    end
  endtask

  task automatic model_write(input logic [23:0] a, input logic [7:0] d);
    if (m_valid && a[23:OFF_W] != m_tag) begin
      push_line();
      m_valid = 1'b0;
    end
    if (!m_valid) begin
      m_valid = 1'b1;
      m_tag   = a[23:OFF_W];
      m_mask  = '0;
    end
    m_data[a[OFF_W-1:0]] = d;
    m_mask[a[OFF_W-1:0]] = 1'b1;
  endtask

  task automatic wr_byte(input logic [23:0] a, input logic [7:0] d, output int stall);
    int budget = 0;
    stall = 0;
    adr = a; dw = d; we = 1'b1;
    @(negedge clk);
    while (!rdy && budget < 500) begin
      stall++; budget++;
      @(negedge clk);
    end
    if (!rdy) begin
      we = 1'b0;
      check("wr_rdy_timeout", rdy, 1);
    end else begin
      model_write(a, d);
    end
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic do_flush();
    flreq = 1'b1;
    if (m_valid) begin
      push_line();
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1 flreq = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget = 0;
    @(negedge clk);
    while ((flbsy || !cmpl || sb.size() != 0) && budget < 3000) begin
      budget++;
      @(negedge clk);
    end
    check({tag, "_flbsy"}, flbsy, 0);
    check({tag, "_cmpl"}, cmpl, 1);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // wack pattern: 0 = held low, 1 = held high, 2 = toggling every cycle.
  initial begin
    wr_if.wack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (wack_mode)
        0:       wr_if.wack = 1'b0;
        1:       wr_if.wack = 1'b1;
        default: wr_if.wack = ~wr_if.wack;
      endcase
    end
  end

  // A beat is consumed at the next rising edge when wreq & wack are seen here.
  always @(negedge clk) begin
    if (xrst && wr_if.wreq) wq_cycles++;
    if (xrst && wr_if.wreq && wr_if.wack) begin
      mon_beats++;
      hdr_adr = wr_if.wadr;
      hdr_len = wr_if.wlen;
      if (sb.size() == 0) begin
        check("beat_expected", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("wadr", wr_if.wadr, mon_e.adr);
        check("wlen", wr_if.wlen, mon_e.len);
        check("wstb", wr_if.wstb, mon_e.stb);
        check("wdata", wr_if.wdata & stbmask(mon_e.stb), mon_e.data & stbmask(mon_e.stb));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, st, st3, budget, wq0;

    // Reset values while xrst is held low.
    #12;
    check("rst_wreq", wr_if.wreq, 0);
    check("rst_wadr", wr_if.wadr, 0);
    check("rst_wdata", wr_if.wdata, 0);
    check("rst_wstb", wr_if.wstb, 0);
    check("rst_wlen", wr_if.wlen, 0);
    check("rst_flbsy", flbsy, 0);
    check("rst_rdy", rdy, 1);
    check("rst_cmpl", cmpl, 1);
    @(posedge clk);
    #1 xrst = 1'b1;
    wack_mode = 1;

    // Full line 0x100..0x1FF, then flush.
    b0 = mon_beats;
    for (int i = 0; i < LB; i++) wr_byte(24'h000100 + 24'(i), 8'(i), st);
    do_flush();
    wait_idle("t1");
    check("t1_beats", mon_beats - b0, 32);
    check("t1_hdr_wadr", hdr_adr, 32'h100);
    check("t1_hdr_wlen", hdr_len, 31);

    // Single byte, then a miss evicts it while the other line takes the new byte.
    b0 = mon_beats;
    wr_byte(24'h000005, 8'h55, st);
    wr_byte(24'h000200, 8'h66, st);
    check("t2_rdy_no_stall", st, 0);
    do_flush();
    wait_idle("t2");
`ifdef OWC_TRIM_BURST_EN
    check("t2_beats", mon_beats - b0, 2);
`else
    check("t2_beats", mon_beats - b0, 64);
`endif

    // Three line misses with wack held low: the third write stalls until a line frees up.
    wack_mode = 0;
    wr_byte(24'h000000, 8'hA0, st);
    wr_byte(24'h000100, 8'hA1, st);
    check("t3_second_no_stall", st, 0);
    fork
      wr_byte(24'h000200, 8'hA2, st3);
      begin
        repeat (30) @(posedge clk);
        #1 wack_mode = 1;
      end
    join
    check("t3_third_stalled", st3 >= 25, 1);
    do_flush();
    wait_idle("t3");

    // Toggling wack: one distinct byte per word so any beat skip or repeat shows in wdata.
    wack_mode = 2;
    b0  = mon_beats;
    wq0 = wq_cycles;
    for (int w = 0; w < LW; w++) wr_byte(24'h000300 + 24'(8 * w), 8'(w + 1), st);
    do_flush();
    wait_idle("t4");
    check("t4_beats", mon_beats - b0, 32);
    check("t4_wreq_cycles_ge63", (wq_cycles - wq0) >= 63, 1);

    // Asynchronous reset in the middle of a burst.
    wack_mode = 1;
    for (int w = 0; w < LW; w++) wr_byte(24'h000400 + 24'(8 * w), 8'(w + 8'h40), st);
    b0 = mon_beats;
    do_flush();
    budget = 0;
    while (mon_beats < b0 + 10 && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    check("t5_reached_beat10", mon_beats >= b0 + 10, 1);
    #2 xrst = 1'b0;
    #1;
    check("t5_rst_wreq", wr_if.wreq, 0);
    check("t5_rst_cmpl", cmpl, 1);
    check("t5_rst_flbsy", flbsy, 0);
    sb.delete();
    m_valid = 1'b0;
    b1 = mon_beats;
    repeat (3) @(posedge clk);
    #1 xrst = 1'b1;
    @(negedge clk);
    check("t5_rdy_after", rdy, 1);
    check("t5_cmpl_after", cmpl, 1);
    check("t5_wreq_after", wr_if.wreq, 0);
    repeat (40) @(negedge clk);
    check("t5_no_more_beats", mon_beats - b1, 0);

    // Dirty bytes only at 0x148..0x15F.
    b0 = mon_beats;
    for (int a = 'h148; a <= 'h15F; a++) wr_byte(24'(a), 8'(a) ^ 8'h5A, st);
    do_flush();
    wait_idle("t6");
`ifdef OWC_TRIM_BURST_EN
    check("t6_hdr_wadr", hdr_adr, 32'h148);
    check("t6_hdr_wlen", hdr_len, 2);
    check("t6_beats", mon_beats - b0, 3);
`else
    check("t6_hdr_wadr", hdr_adr, 32'h100);
    check("t6_hdr_wlen", hdr_len, 31);
    check("t6_beats", mon_beats - b0, 32);
`endif

    // Invalidate drops an active line without any write-back.
    b0 = mon_beats;
    wr_byte(24'h000600, 8'h11, st);
    wr_byte(24'h000607, 8'h22, st);
    m_valid = 1'b0;
    civ = 1'b1;
    @(posedge clk);
    #1 civ = 1'b0;
    repeat (5) @(negedge clk);
    check("t7_cmpl", cmpl, 1);
    check("t7_rdy", rdy, 1);
    check("t7_no_beats", mon_beats - b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
